// File: rtl/pm_ddr_pkg.sv
// Shared definitions for the postmortem DDR record writer: AXI encodings,
// record region layout and the writer's state type.
package pm_ddr_pkg;

    localparam logic [2:0] AWSIZE_8B  = 3'd3;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned NUM_REGIONS  = 5;
    localparam int unsigned RECORD_DEPTH = 50000;

    // Index 0 is the first region (0x0010_0000).
    localparam logic [NUM_REGIONS-1:0][39:0] REGION_BASE = {
        40'h00_0050_0000,
        40'h00_0040_0000,
        40'h00_0030_0000,
        40'h00_0020_0000,
        40'h00_0010_0000
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_RESP   = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } wr_state_e;

    function automatic logic is_beat_aligned(input logic [2:0] addr_lsbs);
        return (addr_lsbs == 3'b000);
    endfunction

endpackage

// File: rtl/postmortem_ddr_writer.sv
// Writes one 64-bit postmortem record per request as a single-beat AXI4 write,
// reporting completion, a sticky error flag and a running record count.
module postmortem_ddr_writer
    import pm_ddr_pkg::*;
#(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int SETTLE = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_done,
    input  logic [ADDR_W-1:0]     i_ddr_addr,
    input  logic [DATA_W-1:0]     i_ddr_data,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,

    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic                  o_err,
    output logic [31:0]           o_wr_cnt
);

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    wr_state_e           state_q, state_d;
    logic [1:0]          settle_cnt_q, settle_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                aw_sent_q, aw_sent_d;
    logic                w_sent_q, w_sent_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                misalign_q, misalign_d;
    logic                err_q, err_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;

    logic                awvalid, wvalid, bready, done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            aw_sent_q    <= 1'b0;
            w_sent_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            misalign_q   <= 1'b0;
            err_q        <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            aw_sent_q    <= aw_sent_d;
            w_sent_q     <= w_sent_d;
            bresp_q      <= bresp_d;
            misalign_q   <= misalign_d;
            err_q        <= err_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        aw_sent_d    = aw_sent_q;
        w_sent_d     = w_sent_q;
        bresp_d      = bresp_q;
        misalign_d   = misalign_q;
        err_d        = err_q;
        wr_cnt_d     = wr_cnt_q;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end

            ST_SETTLE: begin
                if (!i_start) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    // Handler inputs have had time to settle; capture the record.
                    addr_d     = i_ddr_addr;
                    data_d     = i_ddr_data;
                    aw_sent_d  = 1'b0;
                    w_sent_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    misalign_d = !is_beat_aligned(i_ddr_addr[2:0]);
                    state_d    = misalign_d ? ST_DONE : ST_ISSUE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 2'd1;
                end
            end

            ST_ISSUE: begin
                awvalid = !aw_sent_q;
                wvalid  = !w_sent_q;
                if (awvalid && m_axi_awready) aw_sent_d = 1'b1;
                if (wvalid && m_axi_wready)   w_sent_d  = 1'b1;
                if (aw_sent_d && w_sent_d)    state_d   = ST_RESP;
            end

            ST_RESP: begin
                bready = 1'b1;
                if (m_axi_bvalid) begin
                    bresp_d = m_axi_bresp;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                // A misaligned record is reported as an error but never counted.
                if (misalign_q) begin
                    err_d = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + 32'd1;
                    if (bresp_q != RESP_OKAY) err_d = 1'b1;
                end
                state_d = ST_GAP;
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_done        = done;
    assign m_axi_awvalid = awvalid;
    assign m_axi_wvalid  = wvalid;
    assign m_axi_bready  = bready;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AWSIZE_8B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awcache = CACHE_BUF;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;

    assign o_err         = err_q;
    assign o_wr_cnt      = wr_cnt_q;

endmodule

// File: doc/postmortem_ddr_writer.md
POSTMORTEM_DDR_WRITER -- requirements
Module: postmortem_ddr_writer

Interface
REQ-001 Parameter ADDR_W, 40, AXI address width.
REQ-002 Parameter DATA_W, 64, AXI data width; only 64 is supported.
REQ-003 Parameter SETTLE, 2, idle-to-latch delay in cycles (range 1..3).
REQ-004 i_clk  in  1  system clock; all logic on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  write-request level from the postmortem handler; stays high across consecutive records.
REQ-007 o_done  out  1  one-cycle pulse; current record write is complete.
REQ-008 i_ddr_addr  in  40  byte address of the record.
REQ-009 i_ddr_data  in  64  record payload.
REQ-010 m_axi_awaddr/awvalid/awready  out/out/in  40/1/1  AXI4 write-address channel.
REQ-011 m_axi_awlen/awsize/awburst/awcache/awprot  out  8/3/2/4/3  tied to 0 / 3 / INCR(1) / 4'b0011 / 0.
REQ-012 m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  64/8/1/1/1  write-data channel; wstrb = 8'hFF, wlast = 1.
REQ-013 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write-response channel.
REQ-014 o_err  out  1  sticky flag: non-OKAY response or misaligned address.
REQ-015 o_wr_cnt  out  32  count of completed records; wraps at 2^32.

Function
REQ-016 The FSM SHALL have exactly six states: IDLE, SETTLE, ISSUE, RESP, DONE, GAP.
- IDLE -> SETTLE when i_start = 1.
- SETTLE -> ISSUE after SETTLE cycles.
- ISSUE -> RESP when both the AW and W handshakes have completed.
- RESP -> DONE on bvalid & bready.
- DONE -> GAP unconditionally.
- GAP -> IDLE unconditionally.
REQ-017 If i_start drops during SETTLE, the FSM SHALL return to IDLE with no bus activity.
REQ-018 On the SETTLE -> ISSUE transition, the block SHALL latch i_ddr_addr and i_ddr_data. The upstream handler updates them one cycle after its state change, so SETTLE = 2 guarantees the latched values are stable.
REQ-019 In ISSUE, awvalid and wvalid SHALL both assert in the first ISSUE cycle.
- Each valid drops independently after its own handshake.
- Neither valid SHALL deassert before its handshake completes.
- Payload SHALL stay constant while the channel is pending.
REQ-020 AW and W handshakes in the same or in different cycles SHALL both be accepted; a per-channel "sent" flag tracks completion.
REQ-021 bready SHALL be 1 only in RESP.
REQ-022 o_done SHALL be 1 only in DONE, for exactly one cycle per record.
REQ-023 In DONE, o_wr_cnt SHALL increment.
REQ-024 In DONE, o_err SHALL set if the latched bresp was not 2'b00.
REQ-025 If the latched address has addr[2:0] != 0, the FSM SHALL skip ISSUE and RESP (SETTLE -> DONE), set o_err, and still pulse o_done, so the handler never stalls; o_wr_cnt SHALL not increment.
REQ-026 GAP SHALL last one cycle so that the handler's next-state/start transition is observed before a new request is accepted.
REQ-027 A record burst (5 writes per handler sample) SHALL complete with five o_done pulses and no extra write.
REQ-028 If i_start stays high after the fifth done, the block SHALL treat it as a new request; the handler is responsible for dropping i_start.

Reset
REQ-029 On i_rst = 0, all of the following SHALL reset immediately:
- FSM to IDLE.
- awvalid, wvalid, bready, o_done to 0.
- o_err to 0 and o_wr_cnt to 0.
- Latched address and data to 0.
REQ-030 Reset in mid-transaction SHALL abandon the transaction with no completion pulse; the interconnect is reset by the same net.

Structure
REQ-031 A shared package pm_ddr_pkg SHALL hold:
- AXI constants: AWSIZE_8B, BURST_INCR, CACHE_BUF, RESP_OKAY.
- Region base addresses 0x0010_0000, 0x0020_0000, 0x0030_0000, 0x0040_0000, 0x0050_0000.
- Record depth 50000.
REQ-032 The block SHALL be flat, with no sub-module.

Verification
REQ-033 Single write: start=1, addr=0x00_0010_0008, data=0x1122334455667788, awready=wready=1, bvalid 2 cycles after W.
- Required: one AW/W beat carrying exactly these values.
- Required: done pulse 1 cycle after the B handshake; o_wr_cnt = 1.
REQ-034 Five chained requests, with the handler model updating addr to 0x10_0000/0x20_0000/0x30_0000/0x40_0000/0x50_0000 one cycle after each done.
- Required: 5 writes to exactly those addresses, 5 done pulses, no duplicates.
REQ-035 Backpressure: wready held low 10 cycles, awready low 3 cycles.
- Required: valids held and payload stable throughout; exactly one beat per channel.
REQ-036 Error paths:
- bresp = 2'b10 -> o_err = 1, done still pulses, o_wr_cnt increments.
- addr = 0x00_0010_0004 -> no AW/W, done pulses, o_err = 1.
REQ-037 Reset asserted in RESP with bvalid pending -> all outputs 0 immediately; after release, a new start completes normally.
